// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: one-hot coin encodings, coin values,
// change-dispenser state encoding and a coin-to-cents helper.
package vm_pkg;

  localparam logic [2:0] COIN_Q    = 3'b100;
  localparam logic [2:0] COIN_D    = 3'b010;
  localparam logic [2:0] COIN_N    = 3'b001;
  localparam logic [2:0] COIN_NONE = 3'b000;

  localparam int Q_CENTS = 25;
  localparam int D_CENTS = 10;
  localparam int N_CENTS = 5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_DONE     = 2'd2,
    S_ERROR    = 2'd3
  } disp_state_t;

  function automatic int coin_value(input logic [2:0] c);
    case (c)
      COIN_Q:  return Q_CENTS;
      COIN_D:  return D_CENTS;
      COIN_N:  return N_CENTS;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: largest coin not exceeding the amount still owed.
// Purely combinational; yields a nickel for anything below a dime.
module coin_select
  import vm_pkg::*;
#(
  parameter int AMT_W = 8,
  parameter int Q_VAL = Q_CENTS,
  parameter int D_VAL = D_CENTS,
  parameter int N_VAL = N_CENTS
) (
  input  logic [AMT_W-1:0] i_remaining,
  output logic [2:0]       o_coin,
  output logic [AMT_W-1:0] o_value
);

  localparam logic [AMT_W-1:0] L_Q = AMT_W'(Q_VAL);
  localparam logic [AMT_W-1:0] L_D = AMT_W'(D_VAL);
  localparam logic [AMT_W-1:0] L_N = AMT_W'(N_VAL);

  always_comb begin
    o_coin  = COIN_N;
    o_value = L_N;
    if (i_remaining >= L_Q) begin
      o_coin  = COIN_Q;
      o_value = L_Q;
    end else if (i_remaining >= L_D) begin
      o_coin  = COIN_D;
      o_value = L_D;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: returns an amount in cents as a greedy Q/D/N coin stream,
// one coin per valid/ack handshake. Optional per-coin counters: DISP_COUNT_EN.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W = 8,
  parameter int Q_VAL = Q_CENTS,
  parameter int D_VAL = D_CENTS,
  parameter int N_VAL = N_CENTS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ack,
  output logic [2:0]       coin,
  output logic             coin_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remaining
`ifdef DISP_COUNT_EN
  ,
  output logic [3:0]       cnt_q,
  output logic [3:0]       cnt_d,
  output logic [3:0]       cnt_n
`endif
);

  // Handshake: a coin transfers on a rising edge where coin_valid & coin_ack;
  // coin and remaining hold while coin_valid is high and coin_ack is low.
  localparam logic [AMT_W-1:0] L_N = AMT_W'(N_VAL);

  disp_state_t      r_state, w_state_nxt;
  logic [AMT_W-1:0] r_remaining, w_rem_nxt;
  logic [AMT_W-1:0] r_coin_val, w_val_nxt, w_sel_val;
  logic [2:0]       r_coin, w_coin_nxt, w_sel_coin;
  logic             r_coin_valid, w_valid_nxt;
  logic             r_done, r_err;
  logic             w_fire, w_amt_ok;

  assign w_fire   = r_coin_valid & coin_ack;
  assign w_amt_ok = ((amount % L_N) == '0);

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_coin       <= COIN_NONE;
      r_coin_val   <= '0;
      r_coin_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_rem_nxt;
      r_coin       <= w_coin_nxt;
      r_coin_val   <= w_val_nxt;
      r_coin_valid <= w_valid_nxt;
      r_done       <= (w_state_nxt == S_DONE);
      r_err        <= (w_state_nxt == S_ERROR);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!w_amt_ok) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_rem_nxt   = amount;
            w_state_nxt = (amount == '0) ? S_DONE : S_DISPENSE;
          end
        end
      end
      S_DISPENSE: begin
        if (w_fire) begin
          w_rem_nxt = r_remaining - r_coin_val;
          if (w_rem_nxt == '0) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERROR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The coin for next cycle is picked from next cycle's remaining, so the
  // first coin appears one cycle after start and acks can stream back-to-back.
  coin_select #(
    .AMT_W(AMT_W),
    .Q_VAL(Q_VAL),
    .D_VAL(D_VAL),
    .N_VAL(N_VAL)
  ) u_coin_select (
    .i_remaining(w_rem_nxt),
    .o_coin     (w_sel_coin),
    .o_value    (w_sel_val)
  );

  always_comb begin
    w_valid_nxt = (w_state_nxt == S_DISPENSE);
    w_coin_nxt  = COIN_NONE;
    w_val_nxt   = '0;
    if (w_valid_nxt) begin
      w_coin_nxt = w_sel_coin;
      w_val_nxt  = w_sel_val;
    end
  end

  assign coin       = r_coin;
  assign coin_valid = r_coin_valid;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign err        = r_err;
  assign remaining  = r_remaining;

`ifdef DISP_COUNT_EN
  logic [3:0] r_cnt_q, r_cnt_d, r_cnt_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt_q <= '0;
      r_cnt_d <= '0;
      r_cnt_n <= '0;
    end else if (r_state == S_IDLE && start && w_amt_ok) begin
      r_cnt_q <= '0;
      r_cnt_d <= '0;
      r_cnt_n <= '0;
    end else if (w_fire) begin
      if (r_coin == COIN_Q) r_cnt_q <= r_cnt_q + 4'd1;
      if (r_coin == COIN_D) r_cnt_d <= r_cnt_d + 4'd1;
      if (r_coin == COIN_N) r_cnt_n <= r_cnt_n + 4'd1;
    end
  end

  assign cnt_q = r_cnt_q;
  assign cnt_d = r_cnt_d;
  assign cnt_n = r_cnt_n;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random
// amounts with random ack stalls, checked against a greedy-change scoreboard.
module tb_change_dispenser;
  import vm_pkg::*;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] amount;
  logic       coin_ack;
  logic [2:0] coin;
  logic       coin_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] remaining;
`ifdef DISP_COUNT_EN
  logic [3:0] cnt_q, cnt_d, cnt_n;
`endif

  int total = 0;
  int bad   = 0;
  int ack_cnt  = 0;
  int done_cnt = 0;

  logic [2:0] exp_q[$];
  logic [7:0] exp_rem_q[$];

  change_dispenser dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .amount    (amount),
    .coin_ack  (coin_ack),
    .coin      (coin),
    .coin_valid(coin_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .remaining (remaining)
`ifdef DISP_COUNT_EN
    ,
    .cnt_q     (cnt_q),
    .cnt_d     (cnt_d),
    .cnt_n     (cnt_n)
`endif
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Greedy change model
  task automatic push_expected(input logic [7:0] amt);
    int r;
    logic [2:0] c;
    if ((amt % 5) == 0) begin
      r = amt;
      while (r > 0) begin
        if (r >= 25)      c = COIN_Q;
        else if (r >= 10) c = COIN_D;
        else              c = COIN_N;
        exp_q.push_back(c);
        exp_rem_q.push_back(8'(r));
        r = r - coin_value(c);
      end
    end
  endtask

  // Scoreboard: every accepted coin is compared against the model
  always @(negedge clock) begin
    if (!reset && coin_valid && coin_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        check_val("extra_coin", 32'(coin), 32'(COIN_NONE));
      end else begin
        check_val("coin", 32'(coin), 32'(exp_q.pop_front()));
        check_val("coin_rem", 32'(remaining), 32'(exp_rem_q.pop_front()));
      end
    end
    if (!reset && done) begin
      done_cnt++;
      check_val("q_empty_at_done", exp_q.size(), 0);
    end
  end

  // Drivers
  task automatic start_txn(input logic [7:0] amt);
    @(posedge clock); #1;
    start  = 1'b1;
    amount = amt;
    push_expected(amt);
    @(posedge clock); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ack, output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clock); #1;
      if (rand_ack) coin_ack = 1'($urandom_range(0, 1));
      @(negedge clock);
      cycles++;
      if (done) got = 1'b1;
    end
    check_val("done_timeout", 32'(got), 1);
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clock);
    check_val({tag, "_done_pulse"}, 32'(done), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int cyc, a0, d0, amt;
    reset = 1'b1; start = 1'b0; amount = '0; coin_ack = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("rst_coin", 32'(coin), 0);
    check_val("rst_valid", 32'(coin_valid), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_err", 32'(err), 0);
    check_val("rst_rem", 32'(remaining), 0);
    @(posedge clock); #1 reset = 1'b0;

    // 40 cents, ack held: Q, D, N back-to-back
    coin_ack = 1'b1; a0 = ack_cnt; d0 = done_cnt;
    start_txn(8'd40);
    @(negedge clock);
    check_val("t40_first_valid", 32'(coin_valid), 1);
    check_val("t40_first_coin", 32'(coin), 32'(COIN_Q));
    check_val("t40_first_rem", 32'(remaining), 40);
    wait_done(1'b0, cyc);
    check_val("t40_done_lat", cyc, 3);
    check_val("t40_rem_end", 32'(remaining), 0);
    check_idle_after("t40");
    check_val("t40_acks", ack_cnt - a0, 3);
    check_val("t40_dones", done_cnt - d0, 1);
`ifdef DISP_COUNT_EN
    check_val("t40_cnt_q", 32'(cnt_q), 1);
    check_val("t40_cnt_d", 32'(cnt_d), 1);
    check_val("t40_cnt_n", 32'(cnt_n), 1);
`endif

    // 30 cents, first coin stalled 3 cycles
    coin_ack = 1'b0; a0 = ack_cnt; d0 = done_cnt;
    start_txn(8'd30);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val("t30_stall_coin", 32'(coin), 32'(COIN_Q));
      check_val("t30_stall_rem", 32'(remaining), 30);
    end
    @(posedge clock); #1 coin_ack = 1'b1;
    wait_done(1'b0, cyc);
    check_idle_after("t30");
    check_val("t30_acks", ack_cnt - a0, 2);
    check_val("t30_dones", done_cnt - d0, 1);

    // zero amount: straight to done, no coins
    a0 = ack_cnt; d0 = done_cnt;
    start_txn(8'd0);
    @(negedge clock);
    check_val("t0_done", 32'(done), 1);
    check_val("t0_busy", 32'(busy), 1);
    check_val("t0_valid", 32'(coin_valid), 0);
    check_idle_after("t0");
    check_val("t0_acks", ack_cnt - a0, 0);

    // 17 cents: error, then 10 cents gives one dime
    start_txn(8'd17);
    @(negedge clock);
    check_val("t17_err", 32'(err), 1);
    check_val("t17_valid", 32'(coin_valid), 0);
    check_val("t17_rem", 32'(remaining), 0);
    @(negedge clock);
    check_val("t17_err_pulse", 32'(err), 0);
    check_val("t17_busy", 32'(busy), 0);
    a0 = ack_cnt;
    start_txn(8'd10);
    @(negedge clock);
    check_val("t10_coin", 32'(coin), 32'(COIN_D));
    wait_done(1'b0, cyc);
    check_val("t10_done_lat", cyc, 1);
    check_idle_after("t10");
    check_val("t10_acks", ack_cnt - a0, 1);

    // start while busy is ignored
    coin_ack = 1'b0; a0 = ack_cnt; d0 = done_cnt;
    start_txn(8'd20);
    @(posedge clock); #1 start = 1'b1; amount = 8'd25;
    @(posedge clock); #1 start = 1'b0; amount = 8'd0; coin_ack = 1'b1;
    wait_done(1'b0, cyc);
    check_idle_after("t20");
    check_val("t20_acks", ack_cnt - a0, 2);
    check_val("t20_dones", done_cnt - d0, 1);

    // reset in the middle of 255 cents
    coin_ack = 1'b1; d0 = done_cnt;
    start_txn(8'd255);
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_coin", 32'(coin), 0);
    check_val("mid_rst_valid", 32'(coin_valid), 0);
    check_val("mid_rst_busy", 32'(busy), 0);
    check_val("mid_rst_rem", 32'(remaining), 0);
    check_val("mid_rst_done", 32'(done), 0);
    @(negedge clock);
    @(posedge clock); #1 reset = 1'b0;
    check_val("mid_rst_left", exp_q.size(), 7);
    exp_q.delete();
    exp_rem_q.delete();
    a0 = ack_cnt;
    start_txn(8'd5);
    @(negedge clock);
    check_val("t5_coin", 32'(coin), 32'(COIN_N));
    wait_done(1'b0, cyc);
    check_idle_after("t5");
    check_val("t5_acks", ack_cnt - a0, 1);
    check_val("t5_dones", done_cnt - d0, 1);
`ifdef DISP_COUNT_EN
    check_val("t5_cnt_n", 32'(cnt_n), 1);
    check_val("t5_cnt_q", 32'(cnt_q), 0);
`endif

    // random amounts with random ack stalls
    for (int k = 0; k < 8; k++) begin
      d0 = done_cnt;
      amt = $urandom_range(1, 51) * 5;
      coin_ack = 1'($urandom_range(0, 1));
      start_txn(8'(amt));
      wait_done(1'b1, cyc);
      check_idle_after("rand");
      check_val("rand_dones", done_cnt - d0, 1);
      check_val("rand_rem_end", 32'(remaining), 0);
    end

    check_val("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
